latch_gate_seq: RTL and testbench
=================================

Name: latch_gate_seq

Overview:
- Flop-based sequencer that drives the data/enable pair of a level-sensitive (always_latch) capture register.
- It is the transmit end of the latch-gate interface: it presents a data word, holds it stable for a setup window, then raises the gate for a fixed number of cycles.
- It repeats this for a programmed number of incrementing words.
- It sits in front of any latch-based holding register, so the data-before-gate ordering is guaranteed by construction rather than by testbench #delays.

Parameters:
- DW, 8, data word width.
- CW, 4, width of word-count input and internal counter.
- SETUP_CYC, 1, cycles data_o is held stable with gate_o low before each gate pulse (must be >=1).
- GATE_CYC, 1, cycles gate_o is held high per word (must be >=1).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- init_data  input  DW  first data word; sampled with start.
- num_words  input  CW  words to emit; sampled with start.
- data_o  output  DW  data to latch D input.
- gate_o  output  1  latch enable (sel).
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- word_cnt  output  CW  index of the current word (0-based).

Behaviour:
- Reset (rstn low, asynchronous, any state): state=IDLE, data_o=0, gate_o=0, busy=0, done=0, word_cnt=0, internal phase counter=0. The block resumes on the first clk edge after rstn rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, SETUP, GATE, DONE.
- IDLE:
  - start=1 with num_words!=0: data_o<=init_data, word_cnt<=0, latch num_words, go SETUP.
  - start=1 with num_words==0: go DONE directly; data_o is unchanged and gate_o never rises.
  - start=0: stay in IDLE, all outputs hold.
- SETUP:
  - gate_o=0; data_o stable.
  - Stay SETUP_CYC cycles, then go GATE.
- GATE:
  - gate_o=1 for exactly GATE_CYC cycles; data_o must not change while gate_o=1.
  - On the last GATE cycle, if word_cnt==latched_num-1: go DONE.
  - Otherwise: word_cnt<=word_cnt+1, data_o<=data_o+1 (mod 2^DW, e.g. 8'hFF -> 8'h00), go SETUP.
  - gate_o falls in the same edge that data_o changes, so data never changes while the gate is open.
- DONE:
  - done=1 and gate_o=0 for one cycle, then IDLE.
  - data_o retains the last word; word_cnt retains the last index.
- Timing, with start accepted at edge 0:
  - Word k gate is high on cycles 1+k*(S+G)+S .. (k+1)*(S+G), where S=SETUP_CYC and G=GATE_CYC.
  - done is high on cycle N*(S+G)+1.
  - busy is high on cycles 1 .. N*(S+G)+1.
- start while busy (SETUP/GATE/DONE) is ignored. It does not queue, does not restart, and does not alter latched inputs.
- init_data and num_words changes after acceptance have no effect on the run in progress.
- Reset mid-GATE: gate_o drops asynchronously with rstn; no done pulse is issued.
- Invariants:
  - gate_o=1 only in GATE.
  - done and gate_o are never high together.
  - busy=0 implies gate_o=0.

Test Plan:
- Reset check: hold rstn=0 for 3 cycles -> data_o=0, gate_o=0, busy=0, done=0, word_cnt=0.
- Defaults run: start with init_data=1, num_words=8 (S=G=1), and the block feeding an always_latch register:
  - gate_o high on cycles 2,4,...,16.
  - Latch captures 1..8 in order.
  - done=1 on cycle 17; busy high on cycles 1..17.
- Wrap: start with init_data=8'hFE, num_words=4 -> data_o sequence FE, FF, 00, 01; final latch value 01.
- Zero words: start with num_words=0 -> gate_o never rises, done=1 on cycle 1, busy high for that cycle only.
- Ignored start: assert start every cycle during a num_words=3 run -> exactly 3 gate pulses and one done; second run begins only after returning to IDLE.
- Reset mid-run (SETUP_CYC=2, GATE_CYC=3): drop rstn during the second gate pulse -> gate_o=0 immediately, no done pulse; a new start after release produces a full, correct sequence starting from the new init_data.

Source files
------------

// File: rtl/latch_gate_seq.sv
// Transmit-side sequencer for a level-sensitive capture register: presents a
// word, holds it through a setup window, then opens the gate for a fixed pulse.
module latch_gate_seq #(
  parameter int DW        = 8,
  parameter int CW        = 4,
  parameter int SETUP_CYC = 1,
  parameter int GATE_CYC  = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [DW-1:0] init_data,
  input  logic [CW-1:0] num_words,
  output logic [DW-1:0] data_o,
  output logic          gate_o,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] word_cnt
);

  localparam int PMAX = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, GATE, DONE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [CW-1:0] num_q, num_n, cnt_n;
  logic [DW-1:0] data_n;
  logic          setup_last, gate_last, last_word;

  assign setup_last = (phase == PW'(SETUP_CYC - 1));
  assign gate_last  = (phase == PW'(GATE_CYC - 1));
  assign last_word  = (word_cnt == num_q - CW'(1));

  always_comb begin
    state_n = state;
    phase_n = phase;
    num_n   = num_q;
    cnt_n   = word_cnt;
    data_n  = data_o;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            data_n  = init_data;
            cnt_n   = '0;
            num_n   = num_words;
            phase_n = '0;
            state_n = SETUP;
          end else begin
            state_n = DONE;
          end
        end
      end
      SETUP: begin
        if (setup_last) begin
          phase_n = '0;
          state_n = GATE;
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      GATE: begin
        if (gate_last) begin
          phase_n = '0;
          if (last_word) begin
            state_n = DONE;
          end else begin
            // Data advances on the same edge the gate closes.
            cnt_n   = word_cnt + CW'(1);
            data_n  = data_o + DW'(1);
            state_n = SETUP;
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      phase    <= '0;
      num_q    <= '0;
      word_cnt <= '0;
      data_o   <= '0;
      gate_o   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      num_q    <= num_n;
      word_cnt <= cnt_n;
      data_o   <= data_n;
      gate_o   <= (state_n == GATE);
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_latch_gate_seq.sv
// Directed bench for latch_gate_seq: default timing instance plus a
// SETUP_CYC=2 / GATE_CYC=3 instance for the mid-run reset scenario.
module tb_latch_gate_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, start, gate_o, busy, done;
  logic [7:0] init_data, data_o, lat_q;
  logic [3:0] num_words, word_cnt;

  logic       rstn2, start2, gate2, busy2, done2;
  logic [7:0] init2, data2, lat2_q;
  logic [3:0] num2, wcnt2;

  int checks = 0;
  int errors = 0;

  latch_gate_seq u_dut (
    .clk(clk), .rstn(rstn), .start(start), .init_data(init_data),
    .num_words(num_words), .data_o(data_o), .gate_o(gate_o),
    .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  latch_gate_seq #(.SETUP_CYC(2), .GATE_CYC(3)) u_dut2 (
    .clk(clk), .rstn(rstn2), .start(start2), .init_data(init2),
    .num_words(num2), .data_o(data2), .gate_o(gate2),
    .busy(busy2), .done(done2), .word_cnt(wcnt2)
  );

  always_latch if (gate_o) lat_q <= data_o;
  always_latch if (gate2)  lat2_q <= data2;

  task automatic kick(input logic [7:0] d, input logic [3:0] n);
    @(negedge clk);
    init_data = d;
    num_words = n;
    start     = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0; rstn2 = 1'b0; start = 1'b0; start2 = 1'b0;
    init_data = '0; num_words = '0; init2 = '0; num2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset data_o got=%h exp=00", data_o); end
    checks++; if (gate_o !== 1'b0) begin errors++; $display("FAIL reset gate_o got=%b exp=0", gate_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got=%b exp=0", done); end
    checks++; if (word_cnt !== 4'd0) begin errors++; $display("FAIL reset word_cnt got=%0d exp=0", word_cnt); end
    rstn = 1'b1; rstn2 = 1'b1;
  endtask

  task automatic test_defaults;
    logic eg, ed, eb;
    kick(8'h01, 4'd8);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      start = 1'b0;
      eg = (k >= 2 && k <= 16 && k % 2 == 0);
      ed = (k == 17);
      eb = (k <= 17);
      checks++; if (gate_o !== eg) begin errors++; $display("FAIL dflt gate cyc%0d got=%b exp=%b", k, gate_o, eg); end
      checks++; if (done !== ed) begin errors++; $display("FAIL dflt done cyc%0d got=%b exp=%b", k, done, ed); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL dflt busy cyc%0d got=%b exp=%b", k, busy, eb); end
      if (eg) begin
        checks++; if (data_o !== 8'(k / 2)) begin errors++; $display("FAIL dflt data cyc%0d got=%h exp=%h", k, data_o, 8'(k / 2)); end
      end
      if (k >= 3 && k <= 17 && k % 2 == 1) begin
        checks++; if (lat_q !== 8'((k - 1) / 2)) begin errors++; $display("FAIL dflt latch cyc%0d got=%h exp=%h", k, lat_q, 8'((k - 1) / 2)); end
      end
    end
    checks++; if (lat_q !== 8'h08) begin errors++; $display("FAIL dflt final latch got=%h exp=08", lat_q); end
    checks++; if (word_cnt !== 4'd7) begin errors++; $display("FAIL dflt final word_cnt got=%0d exp=7", word_cnt); end
    checks++; if (data_o !== 8'h08) begin errors++; $display("FAIL dflt final data got=%h exp=08", data_o); end
  endtask

  task automatic test_wrap;
    logic [7:0] ev;
    kick(8'hFE, 4'd4);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k <= 8 && k % 2 == 0) begin
        ev = 8'hFE + 8'(k / 2 - 1);
        checks++; if (data_o !== ev) begin errors++; $display("FAIL wrap data cyc%0d got=%h exp=%h", k, data_o, ev); end
      end
      checks++; if (done !== (k == 9)) begin errors++; $display("FAIL wrap done cyc%0d got=%b exp=%b", k, done, k == 9); end
    end
    checks++; if (lat_q !== 8'h01) begin errors++; $display("FAIL wrap final latch got=%h exp=01", lat_q); end
    checks++; if (word_cnt !== 4'd3) begin errors++; $display("FAIL wrap final word_cnt got=%0d exp=3", word_cnt); end
  endtask

  task automatic test_zero_words;
    kick(8'hAA, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++; if (gate_o !== 1'b0) begin errors++; $display("FAIL zero gate cyc%0d got=%b exp=0", k, gate_o); end
      checks++; if (done !== (k == 1)) begin errors++; $display("FAIL zero done cyc%0d got=%b exp=%b", k, done, k == 1); end
      checks++; if (busy !== (k == 1)) begin errors++; $display("FAIL zero busy cyc%0d got=%b exp=%b", k, busy, k == 1); end
      checks++; if (data_o !== 8'h01) begin errors++; $display("FAIL zero data cyc%0d got=%h exp=01", k, data_o); end
    end
  endtask

  task automatic test_ignored_start;
    int   pulses = 0, dones = 0, waited = 0;
    logic pg = 1'b0;
    kick(8'h10, 4'd3);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin init_data = 8'h55; num_words = 4'd9; end
      if (gate_o && !pg) pulses++;
      pg = gate_o;
      if (done) dones++;
      if (k <= 6 && k % 2 == 0) begin
        checks++; if (data_o !== 8'(8'h10 + k / 2 - 1)) begin errors++; $display("FAIL ign data cyc%0d got=%h exp=%h", k, data_o, 8'(8'h10 + k / 2 - 1)); end
      end
      if (k == 7) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign done cyc7 got=%b exp=1", done); end
        checks++; if (word_cnt !== 4'd2) begin errors++; $display("FAIL ign word_cnt cyc7 got=%0d exp=2", word_cnt); end
      end
      if (k == 8) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign busy cyc8 got=%b exp=0", busy); end
        checks++; if (pulses != 3) begin errors++; $display("FAIL ign pulses got=%0d exp=3", pulses); end
        checks++; if (dones != 1) begin errors++; $display("FAIL ign dones got=%0d exp=1", dones); end
      end
      if (k == 9) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign busy cyc9 got=%b exp=1", busy); end
        checks++; if (data_o !== 8'h55) begin errors++; $display("FAIL ign rerun data got=%h exp=55", data_o); end
      end
    end
    start  = 1'b0;
    pulses = 0;
    while (busy && waited < 40) begin
      @(negedge clk);
      waited++;
      if (gate_o && !pg) pulses++;
      pg = gate_o;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign rerun timeout busy got=%b exp=0", busy); end
    checks++; if (pulses != 9) begin errors++; $display("FAIL ign rerun pulses got=%0d exp=9", pulses); end
  endtask

  task automatic test_reset_midrun;
    logic eg;
    @(negedge clk);
    init2 = 8'h20; num2 = 4'd4; start2 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      eg = (k >= 3 && k <= 5) || (k >= 8);
      checks++; if (gate2 !== eg) begin errors++; $display("FAIL mid gate cyc%0d got=%b exp=%b", k, gate2, eg); end
    end
    checks++; if (data2 !== 8'h21) begin errors++; $display("FAIL mid data before rst got=%h exp=21", data2); end
    #1 rstn2 = 1'b0;
    #1;
    checks++; if (gate2 !== 1'b0) begin errors++; $display("FAIL mid async gate got=%b exp=0", gate2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL mid async busy got=%b exp=0", busy2); end
    checks++; if (data2 !== 8'h00) begin errors++; $display("FAIL mid async data got=%h exp=00", data2); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL mid done in rst got=%b exp=0", done2); end
    end
    rstn2 = 1'b1;
    @(negedge clk);
    init2 = 8'h80; num2 = 4'd2; start2 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      eg = (k >= 3 && k <= 5) || (k >= 8 && k <= 10);
      checks++; if (gate2 !== eg) begin errors++; $display("FAIL mid2 gate cyc%0d got=%b exp=%b", k, gate2, eg); end
      checks++; if (done2 !== (k == 11)) begin errors++; $display("FAIL mid2 done cyc%0d got=%b exp=%b", k, done2, k == 11); end
      checks++; if (busy2 !== (k <= 11)) begin errors++; $display("FAIL mid2 busy cyc%0d got=%b exp=%b", k, busy2, k <= 11); end
      if (eg) begin
        checks++; if (data2 !== (k >= 8 ? 8'h81 : 8'h80)) begin errors++; $display("FAIL mid2 data cyc%0d got=%h exp=%h", k, data2, (k >= 8 ? 8'h81 : 8'h80)); end
      end
    end
    checks++; if (lat2_q !== 8'h81) begin errors++; $display("FAIL mid2 final latch got=%h exp=81", lat2_q); end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_wrap();
    test_zero_words();
    test_ignored_start();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
